// File: rtl/dcsformer_seq_ctrl.sv
// dcsformer_seq_ctrl: buffers host bytes and replays them to the DCSformer core as gap-free bursts, then drains results
// Optional watchdog on WAIT_R/COLLECT enabled by defining DCS_SEQ_TIMEOUT_EN.
module dcsformer_seq_ctrl #(
  parameter int I_LEN  = 128,
  parameter int W_LEN  = 8,
  parameter int O_LEN  = 8,
  parameter int TO_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        core_i_valid,
  output logic        core_w_valid,
  output logic [7:0]  core_data,
  input  logic        core_w_ready,
  input  logic        core_o_valid,
  input  logic [31:0] core_o_data,
  output logic        m_valid,
  output logic [31:0] m_data,
  input  logic        m_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        err_unexp,
  output logic        err_timeout
);
  localparam int B  = I_LEN > W_LEN ? I_LEN : W_LEN;
  localparam int CW = $clog2(B);
  localparam int OW = $clog2(O_LEN);
  typedef enum logic [2:0] {FILL_I, BURST_I, WAIT_R, FILL_W, BURST_W, COLLECT, DRAIN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [OW-1:0] ocnt, dcnt;
  logic [7:0] byte_buf [B];
  logic [31:0] obuf [O_LEN];
  logic acc, last, o_last, d_last;
  assign acc = s_valid && s_ready;
  assign last = (state == FILL_I || state == BURST_I) ? cnt == CW'(I_LEN - 1) : cnt == CW'(W_LEN - 1);
  assign o_last = ocnt == OW'(O_LEN - 1);
  assign d_last = dcnt == OW'(O_LEN - 1);
  assign m_valid = state == DRAIN;
  assign m_data = m_valid ? obuf[dcnt] : '0;
  assign frame_done = m_valid && m_ready && d_last;
  assign busy = !(state == FILL_I && cnt == '0);
  always_ff @(posedge clk) begin
    if (acc) byte_buf[cnt] <= s_data;
    if (state == COLLECT && core_o_valid) obuf[ocnt] <= core_o_data;
  end
`ifdef DCS_SEQ_TIMEOUT_EN
  logic [15:0] wd;
`else
  logic [31:0] unused_to;
  assign unused_to = TO_CYC;
  assign err_timeout = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL_I;
      cnt <= '0;
      ocnt <= '0;
      dcnt <= '0;
      s_ready <= 1'b0;
      core_i_valid <= 1'b0;
      core_w_valid <= 1'b0;
      core_data <= '0;
      err_unexp <= 1'b0;
`ifdef DCS_SEQ_TIMEOUT_EN
      wd <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      core_i_valid <= state == BURST_I;
      core_w_valid <= state == BURST_W;
      core_data <= (state == BURST_I || state == BURST_W) ? byte_buf[cnt] : '0;
      if (core_o_valid && state != COLLECT) err_unexp <= 1'b1;
      case (state)
        FILL_I, FILL_W: begin
          s_ready <= !(acc && last);
          if (acc) begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) state <= state == FILL_I ? BURST_I : BURST_W;
          end
        end
        BURST_I, BURST_W: begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) state <= state == BURST_I ? WAIT_R : COLLECT;
        end
        WAIT_R: if (core_w_ready) begin
          state <= FILL_W;
          s_ready <= 1'b1;
        end
        COLLECT: if (core_o_valid) begin
          ocnt <= o_last ? '0 : ocnt + 1'b1;
          if (o_last) state <= DRAIN;
        end
        DRAIN: if (m_ready) begin
          dcnt <= d_last ? '0 : dcnt + 1'b1;
          if (d_last) begin
            state <= FILL_I;
            s_ready <= 1'b1;
          end
        end
        default: state <= FILL_I;
      endcase
`ifdef DCS_SEQ_TIMEOUT_EN
      // Only cycles without progress in the two waiting states advance the watchdog
      if ((state == WAIT_R && !core_w_ready) || (state == COLLECT && !core_o_valid)) begin
        wd <= wd + 1'b1;
        if (wd == 16'(TO_CYC - 1)) begin
          err_timeout <= 1'b1;
          state <= FILL_I;
          cnt <= '0;
          ocnt <= '0;
          s_ready <= 1'b1;
          wd <= '0;
        end
      end else wd <= '0;
`endif
    end
  end
endmodule
